// File: rtl/fp_pkg.sv
// Shared FP32 types, constants and FSM states for the accumulator.
// Optional build macro used by the accumulator: FP_SPECIAL_EN.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP_NINF = 32'hFF80_0000;
  localparam int          FP_BIAS = 127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_OUT
  } acc_state_t;

endpackage

// File: rtl/fp_align.sv
// Operand unpack, magnitude swap and alignment shift.
// Zero exponent flushes to zero; shifted-out bits are truncated.
module fp_align
  import fp_pkg::*;
(
  input  fp32_t       i_x,
  input  fp32_t       i_y,
  output logic [23:0] o_man_a,
  output logic [23:0] o_man_b,
  output logic [7:0]  o_exp,
  output logic        o_sign_a,
  output logic        o_sign_b
);

  logic [23:0] w_mx;
  logic [23:0] w_my;
  logic [23:0] w_mb;
  logic [7:0]  w_eb;
  logic [7:0]  w_diff;

  // Larger magnitude becomes A; B is right-shifted onto A's exponent
  always_comb begin
    w_mx = (i_x.exp == 8'd0) ? 24'd0 : {1'b1, i_x.man};
    w_my = (i_y.exp == 8'd0) ? 24'd0 : {1'b1, i_y.man};
    if ({i_x.exp, w_mx} >= {i_y.exp, w_my}) begin
      o_man_a  = w_mx;
      o_exp    = i_x.exp;
      o_sign_a = i_x.sign;
      w_mb     = w_my;
      w_eb     = i_y.exp;
      o_sign_b = i_y.sign;
    end else begin
      o_man_a  = w_my;
      o_exp    = i_y.exp;
      o_sign_a = i_y.sign;
      w_mb     = w_mx;
      w_eb     = i_x.exp;
      o_sign_b = i_x.sign;
    end
    w_diff  = o_exp - w_eb;
    o_man_b = (w_diff >= 8'd25) ? 24'd0 : (w_mb >> w_diff);
  end

endmodule

// File: rtl/accumulator_unit.sv
// Sequential FP32 accumulator: align, add, iterative normalise.
// Build macro FP_SPECIAL_EN enables Inf/NaN handling.
module accumulator_unit
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      dataP,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      dataS,
  output logic [CNT_W-1:0] term_count,
  output logic             busy
);

  acc_state_t       r_state;
  acc_state_t       w_next;
  fp32_t            r_acc;
  fp32_t            r_term;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_ma;
  logic [23:0]      r_mb;
  logic [7:0]       r_exp;
  logic             r_sa;
  logic             r_sb;
  logic [24:0]      r_man;
  logic             r_sign;
  logic             r_spec;
  fp32_t            r_spec_val;

  logic [23:0]      w_ma;
  logic [23:0]      w_mb;
  logic [7:0]       w_exp;
  logic             w_sa;
  logic             w_sb;
  logic             w_spec;
  fp32_t            w_spec_val;
  logic             w_norm_done;
  fp32_t            w_norm_res;
  fp32_t            w_inf;

  fp_align u_align (
    .i_x      (r_acc),
    .i_y      (r_term),
    .o_man_a  (w_ma),
    .o_man_b  (w_mb),
    .o_exp    (w_exp),
    .o_sign_a (w_sa),
    .o_sign_b (w_sb)
  );

`ifdef FP_SPECIAL_EN
  logic w_acc_nan;
  logic w_acc_inf;
  logic w_trm_nan;
  logic w_trm_inf;

  // Inf/NaN classification; a special accumulator is sticky
  always_comb begin
    w_acc_nan  = (r_acc.exp == 8'hFF) && (r_acc.man != 23'd0);
    w_acc_inf  = (r_acc.exp == 8'hFF) && (r_acc.man == 23'd0);
    w_trm_nan  = (r_term.exp == 8'hFF) && (r_term.man != 23'd0);
    w_trm_inf  = (r_term.exp == 8'hFF) && (r_term.man == 23'd0);
    w_spec     = 1'b1;
    w_spec_val = r_acc;
    if (w_acc_nan) begin
      w_spec_val = r_acc;
    end else if (w_trm_nan) begin
      w_spec_val = FP_QNAN;
    end else if (w_acc_inf) begin
      if (w_trm_inf && (r_term.sign != r_acc.sign))
        w_spec_val = FP_QNAN;
    end else if (w_trm_inf) begin
      w_spec_val = r_term;
    end else begin
      w_spec = 1'b0;
    end
  end
`else
  assign w_spec     = 1'b0;
  assign w_spec_val = '0;
`endif

  // Normalisation step: decides completion and the packed result
  always_comb begin
    w_inf       = {r_sign, 8'hFF, 23'd0};
    w_norm_done = 1'b1;
    w_norm_res  = '0;
    if (r_man[24]) begin
      if (r_exp >= 8'd254)
        w_norm_res = w_inf;
      else
        w_norm_res = {r_sign, r_exp + 8'd1, r_man[23:1]};
    end else if (r_man == 25'd0) begin
      w_norm_res = '0;
    end else if (r_man[23]) begin
      if (r_exp == 8'hFF)
        w_norm_res = w_inf;
      else
        w_norm_res = {r_sign, r_exp, r_man[22:0]};
    end else if (r_exp <= 8'd1) begin
      w_norm_res = '0;
    end else begin
      w_norm_done = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state and state-decoded handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid)
          w_next = S_ALIGN;
      end
      S_ALIGN: w_next = S_ADD;
      S_ADD: begin
        if (r_spec)
          w_next = r_last ? S_OUT : S_IDLE;
        else
          w_next = S_NORM;
      end
      S_NORM: begin
        if (w_norm_done)
          w_next = r_last ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers advanced by the current state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_term     <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_exp      <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_man      <= '0;
      r_sign     <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_val <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_term <= dataP;
            r_last <= last;
            if (!(&r_cnt))
              r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ALIGN: begin
          r_ma       <= w_ma;
          r_mb       <= w_mb;
          r_exp      <= w_exp;
          r_sa       <= w_sa;
          r_sb       <= w_sb;
          r_spec     <= w_spec;
          r_spec_val <= w_spec_val;
        end
        S_ADD: begin
          r_sign <= r_sa;
          if (r_spec)
            r_acc <= r_spec_val;
          else if (r_sa == r_sb)
            r_man <= {1'b0, r_ma} + {1'b0, r_mb};
          else
            r_man <= {1'b0, r_ma} - {1'b0, r_mb};
        end
        S_NORM: begin
          if (w_norm_done) begin
            r_acc <= w_norm_res;
          end else begin
            r_man <= r_man << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dataS      = r_acc;
  assign term_count = r_cnt;

endmodule

// File: tb/tb_accumulator_unit.sv
// Directed self-checking bench for accumulator_unit.
// Define FP_SPECIAL_EN to also exercise Inf/NaN handling.
module tb_accumulator_unit;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      dataP = '0;
  logic             last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      dataS;
  logic [CNT_W-1:0] term_count;
  logic             busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accumulator_unit #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dataP      (dataP),
    .last       (last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dataS      (dataS),
    .term_count (term_count),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] s;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dataP    = d;
    last     = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic lat(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!in_ready && n < 60);
  endtask

  task automatic wait_out();
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) chk("out_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic get(input string name, input logic [31:0] es,
                     input logic [CNT_W-1:0] ec);
    wait_out();
    chk({name, "_dataS"}, dataS, es);
    chk({name, "_count"}, {16'd0, term_count}, {16'd0, ec});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_dataS"}, dataS, 32'h0);
    chk({name, "_count"}, {16'd0, term_count}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t tv[6];
    int   n;

    tv[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    tv[1] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    tv[2] = '{32'h3F80_0000, 32'h3400_0000, 32'h3F80_0001};
    tv[3] = '{32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000};
    tv[4] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000};
    tv[5] = '{32'h4000_0000, 32'hC040_0000, 32'hBF80_0000};

    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send(tv[i].t0, 1'b0);
      lat(n);
      chk($sformatf("vec%0d_lat", i), n, 32'd3);
      send(tv[i].t1, 1'b1);
      get($sformatf("vec%0d", i), tv[i].s, 2);
    end

    // 1.0 - (1-2^-24) truncates to 2^-23: 23 left shifts
    send(32'hBF7F_FFFF, 1'b0);
    lat(n);
    send(32'h3F80_0000, 1'b0);
    lat(n);
    chk("long_lat", n, 32'd26);
    send(32'h0000_0000, 1'b1);
    get("long", 32'h3400_0000, 3);

    // reset in the middle of NORM
    send(32'hBF7F_FFFF, 1'b0);
    lat(n);
    send(32'h3F80_0000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_norm_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset("abort");

    // result held while out_ready is low
    send(32'h40A0_0000, 1'b1);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_dataS", i), dataS, 32'h40A0_0000);
      chk($sformatf("hold%0d_count", i), {16'd0, term_count}, 32'd1);
      @(negedge clk);
    end
    get("hold", 32'h40A0_0000, 1);

    // in_valid held high: zero terms accepted on edges 1, 5 and 9
    @(negedge clk);
    in_valid = 1'b1;
    dataP    = 32'h0;
    last     = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(32'h3F80_0000, 1'b1);
    wait_out();
    in_valid = 1'b1;
    dataP    = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_noaccept%0d", i), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    get("stream", 32'h3F80_0000, 4);

`ifdef FP_SPECIAL_EN
    send(32'h7F80_0000, 1'b0);
    lat(n);
    chk("spec_lat", n, 32'd2);
    send(32'hFF80_0000, 1'b0);
    send(32'h3F80_0000, 1'b1);
    get("spec_nan", 32'h7FC0_0000, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
